// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Multiplexes a four-digit seven-segment display. Each digit gets a slot of
//   DIV clocks. The first GUARD clocks of every slot keep all anodes off while
//   digit_data already carries the next digit's nibble. Updates are staged in
//   pending registers and copied to the display only at a frame boundary, so a
//   frame never shows a mix of old and new digits.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   value      : four nibbles, nibble k drives digit k (digit 3 is the MSD)
//   dp_mask    : bit k lights the decimal point of digit k
//   lzb        : leading-zero blanking enable
//   load       : one-cycle strobe capturing value/dp_mask/lzb into pending
//   digit_data : nibble for the digit decoder
//   anode_n    : active-low digit enables, bit k selects digit k
//   dp_n       : active-low decimal point of the active digit
//   busy       : a captured update has not been committed yet
//   frame_tick : one-cycle pulse on the first cycle of each frame
module display_scan_controller #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        lzb,
    input  logic        load,
    output logic [3:0]  digit_data,
    output logic [3:0]  anode_n,
    output logic        dp_n,
    output logic        busy,
    output logic        frame_tick
);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [15:0] TICK_LAST  = 16'(DIV - 1);
    localparam logic [15:0] TICK_GUARD = 16'(GUARD);

    logic [15:0] tick_q, tick_d;
    logic [1:0]  idx_q, idx_d;
    logic [0:0]  state_q, state_d;

    logic [15:0] disp_val_q, pend_val_q;
    logic [3:0]  disp_dp_q, pend_dp_q;
    logic        disp_lzb_q, pend_lzb_q;
    logic        busy_q, busy_d;
    logic        frame_tick_q, frame_tick_d;

    logic        slot_end;
    logic        frame_end;
    logic        commit;

    always_comb begin
        slot_end  = (tick_q == TICK_LAST);
        frame_end = slot_end && (idx_q == 2'd3);
        commit    = frame_end && busy_q;

        tick_d = slot_end ? '0 : tick_q + 16'd1;
        // 2-bit index wraps 3->0 on its own
        idx_d  = slot_end ? idx_q + 2'd1 : idx_q;

        state_d = state_q;
        case (state_q)
            ST_GUARD: if (tick_d == TICK_GUARD) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end)             state_d = ST_GUARD;
            default:                            state_d = ST_GUARD;
        endcase

        // A load in the commit cycle keeps busy set: the commit consumed the
        // old pending contents and the new ones still await the next frame.
        if (load)        busy_d = 1'b1;
        else if (commit) busy_d = 1'b0;
        else             busy_d = busy_q;

        // Registered so the pulse lands on idx 0 / tick 0 only after a wrap
        // from digit 3, never on the first frame after reset.
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q       <= '0;
            idx_q        <= '0;
            state_q      <= ST_GUARD;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_lzb_q   <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_lzb_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_tick_q <= frame_tick_d;
            if (commit) begin
                disp_val_q <= pend_val_q;
                disp_dp_q  <= pend_dp_q;
                disp_lzb_q <= pend_lzb_q;
            end
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_mask;
                pend_lzb_q <= lzb;
            end
        end
    end

    // Outputs depend on registered state only.
    logic [3:0] blank;
    logic       lit;

    always_comb begin
        blank[0] = 1'b0;
        blank[1] = disp_lzb_q && (disp_val_q[15:4]  == 12'h000);
        blank[2] = disp_lzb_q && (disp_val_q[15:8]  == 8'h00);
        blank[3] = disp_lzb_q && (disp_val_q[15:12] == 4'h0);

        lit        = (state_q == ST_SHOW) && !blank[idx_q];
        digit_data = disp_val_q[{idx_q, 2'b00} +: 4];
        anode_n    = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        dp_n       = ~(lit && disp_dp_q[idx_q]);
    end

    assign busy       = busy_q;
    assign frame_tick = frame_tick_q;

endmodule
